// File: rtl/recip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : recip_pkg
// Description : Shared constants and in-flight tag type for the reciprocal
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package recip_pkg;

    localparam int MANT_WIDTH_DEF = 8;
    localparam int NREQ_MAX       = 8;
    // Sized for the largest supported requester count so one tag type serves all builds
    localparam int ID_W           = $clog2(NREQ_MAX);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/recip_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : recip_scheduler_if
// Description : Requester, reciprocal-unit and response signals of the
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface recip_scheduler_if #(
    parameter int NREQ       = 4,
    parameter int MANT_WIDTH = 8
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ*MANT_WIDTH-1:0] req_data;
    logic [NREQ-1:0]            req_ready;
    logic [MANT_WIDTH-1:0]      recip_in;
    logic [MANT_WIDTH-1:0]      recip_out;
    logic [NREQ-1:0]            rsp_valid;
    logic [NREQ*MANT_WIDTH-1:0] rsp_data;
    logic [NREQ-1:0]            rsp_ready;
    logic                       busy;

    modport master (
        output req_valid, req_data, rsp_ready, recip_out,
        input  req_ready, recip_in, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_data, rsp_ready, recip_out,
        output req_ready, recip_in, rsp_valid, rsp_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/recip_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; the eligible requester
//               closest at or after the pointer wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = 3
) (
    input  logic [NREQ-1:0] i_eligible,
    input  logic [ID_W-1:0] i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [ID_W-1:0] o_id,
    output logic            o_valid
);
    int w_dist;
    int w_best;

    // Rotational distance from the pointer is the priority; smallest wins
    always_comb begin
        o_grant = '0;
        o_id    = '0;
        o_valid = 1'b0;
        w_best  = NREQ;
        w_dist  = 0;
        for (int j = 0; j < NREQ; j++) begin
            w_dist = (j + NREQ - int'(i_ptr)) % NREQ;
            if (i_eligible[j] && (w_dist < w_best)) begin
                w_best     = w_dist;
                o_grant    = '0;
                o_grant[j] = 1'b1;
                o_id       = ID_W'(j);
                o_valid    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/recip_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : recip_scheduler
// Description : Time-shares one reciprocal unit among NREQ requesters with
//               round-robin issue, a latency-matched tag pipeline and
//               one-entry response slots.
// Revision    : 1.0 - initial release
// ============================================================================
module recip_scheduler
    import recip_pkg::*;
#(
    parameter int MANT_WIDTH = MANT_WIDTH_DEF,
    parameter int NREQ       = 4,
    parameter int RECIP_LAT  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    recip_scheduler_if.slave bus
);
    logic [NREQ-1:0]            r_rsp_valid_q, w_rsp_valid_d;
    logic [NREQ*MANT_WIDTH-1:0] r_rsp_data_q,  w_rsp_data_d;
    logic [NREQ-1:0]            r_inflight_q,  w_inflight_d;
    logic [ID_W-1:0]            r_ptr_q,       w_ptr_d;
    tag_t                       r_tag_q [RECIP_LAT];
    tag_t                       w_tag_new;
    tag_t                       w_cap;
    logic [NREQ-1:0]            w_eligible;
    logic [NREQ-1:0]            w_grant;
    logic [ID_W-1:0]            w_gnt_id;
    logic                       w_gnt_valid;
    logic [MANT_WIDTH-1:0]      w_recip_in;

    assign w_eligible = bus.req_valid & ~r_rsp_valid_q & ~r_inflight_q;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .i_eligible (w_eligible),
        .i_ptr      (r_ptr_q),
        .o_grant    (w_grant),
        .o_id       (w_gnt_id),
        .o_valid    (w_gnt_valid)
    );

    always_comb begin
        w_recip_in = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_grant[j]) begin
                w_recip_in = bus.req_data[j*MANT_WIDTH +: MANT_WIDTH];
            end
        end
    end

    always_comb begin
        w_ptr_d = r_ptr_q;
        if (w_gnt_valid) begin
            w_ptr_d = (int'(w_gnt_id) == NREQ - 1) ? '0 : w_gnt_id + ID_W'(1);
        end
    end

    always_comb begin
        w_tag_new       = '0;
        w_tag_new.valid = w_gnt_valid;
        w_tag_new.id    = w_gnt_id;
    end

    assign w_cap = r_tag_q[RECIP_LAT-1];

    // A slot being captured was empty, so pop and capture never collide on one index
    always_comb begin
        w_rsp_valid_d = r_rsp_valid_q;
        w_rsp_data_d  = r_rsp_data_q;
        w_inflight_d  = r_inflight_q | w_grant;
        for (int j = 0; j < NREQ; j++) begin
            if (bus.rsp_ready[j]) begin
                w_rsp_valid_d[j] = 1'b0;
            end
            if (w_cap.valid && (w_cap.id == ID_W'(j))) begin
                w_rsp_valid_d[j]                         = 1'b1;
                w_rsp_data_d[j*MANT_WIDTH +: MANT_WIDTH] = bus.recip_out;
                w_inflight_d[j]                          = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid_q <= '0;
            r_rsp_data_q  <= '0;
            r_inflight_q  <= '0;
            r_ptr_q       <= '0;
            for (int s = 0; s < RECIP_LAT; s++) begin
                r_tag_q[s] <= '0;
            end
        end else begin
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_data_q  <= w_rsp_data_d;
            r_inflight_q  <= w_inflight_d;
            r_ptr_q       <= w_ptr_d;
            r_tag_q[0]    <= w_tag_new;
            for (int s = 1; s < RECIP_LAT; s++) begin
                r_tag_q[s] <= r_tag_q[s-1];
            end
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.recip_in  = w_recip_in;
    assign bus.rsp_valid = r_rsp_valid_q;
    assign bus.rsp_data  = r_rsp_data_q;
    assign bus.busy      = (|r_inflight_q) | (|r_rsp_valid_q);

endmodule
`default_nettype wire

// File: tb/tb_recip_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_recip_scheduler
// Description : Directed, table-driven bench for recip_scheduler with an
//               inverting one-cycle reciprocal stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_recip_scheduler;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    recip_scheduler_if #(.NREQ(4), .MANT_WIDTH(8)) u_if ();

    recip_scheduler #(
        .MANT_WIDTH (8),
        .NREQ       (4),
        .RECIP_LAT  (1)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    // Reciprocal stand-in: registered bitwise inverse
    always @(posedge clk) u_if.recip_out <= ~u_if.recip_in;

    typedef struct {
        bit          rst_before;
        logic [3:0]  req_valid;
        logic [31:0] req_data;
        logic [3:0]  rsp_ready;
        logic [3:0]  exp_ready;
        logic [7:0]  exp_in;
        logic [3:0]  exp_rv;
        logic [31:0] exp_rd;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [18];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(input bit rb, input logic [3:0] v, input logic [31:0] d,
                                input logic [3:0] r, input logic [3:0] er, input logic [7:0] ei,
                                input logic [3:0] ev, input logic [31:0] ed, input logic eb);
        vec_t t;
        t.rst_before = rb; t.req_valid = v; t.req_data = d; t.rsp_ready = r;
        t.exp_ready  = er; t.exp_in = ei; t.exp_rv = ev; t.exp_rd = ed; t.exp_busy = eb;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] rdy, input logic [7:0] rin,
                                 input logic [3:0] rv, input logic [31:0] rd, input logic bsy);
        check({tag, ".req_ready"}, 32'(u_if.req_ready), 32'(rdy));
        check({tag, ".recip_in"},  32'(u_if.recip_in),  32'(rin));
        check({tag, ".rsp_valid"}, 32'(u_if.rsp_valid), 32'(rv));
        check({tag, ".rsp_data"},  u_if.rsp_data,       rd);
        check({tag, ".busy"},      32'(u_if.busy),      32'(bsy));
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] r);
        u_if.req_valid = v;
        u_if.req_data  = d;
        u_if.rsp_ready = r;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(4'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Round-robin, all requesters valid, all consumers ready
        vecs[0]  = mk(1, 4'hF, 32'h40302010, 4'hF, 4'b0001, 8'h10, 4'b0000, 32'h00000000, 1'b0);
        vecs[1]  = mk(0, 4'hF, 32'h40302010, 4'hF, 4'b0010, 8'h20, 4'b0000, 32'h00000000, 1'b1);
        vecs[2]  = mk(0, 4'hF, 32'h40302010, 4'hF, 4'b0100, 8'h30, 4'b0001, 32'h000000EF, 1'b1);
        vecs[3]  = mk(0, 4'hF, 32'h40302010, 4'hF, 4'b1000, 8'h40, 4'b0010, 32'h0000DFEF, 1'b1);
        vecs[4]  = mk(0, 4'hF, 32'h40302010, 4'hF, 4'b0001, 8'h10, 4'b0100, 32'h00CFDFEF, 1'b1);
        vecs[5]  = mk(0, 4'hF, 32'h40302010, 4'hF, 4'b0010, 8'h20, 4'b1000, 32'hBFCFDFEF, 1'b1);
        vecs[6]  = mk(0, 4'hF, 32'h40302010, 4'hF, 4'b0100, 8'h30, 4'b0001, 32'hBFCFDFEF, 1'b1);
        vecs[7]  = mk(0, 4'hF, 32'h40302010, 4'hF, 4'b1000, 8'h40, 4'b0010, 32'hBFCFDFEF, 1'b1);
        // Backpressure on requester 2: it stays full, others rotate 0,1,3
        vecs[8]  = mk(1, 4'hF, 32'h40302010, 4'hB, 4'b0001, 8'h10, 4'b0000, 32'h00000000, 1'b0);
        vecs[9]  = mk(0, 4'hF, 32'h40302010, 4'hB, 4'b0010, 8'h20, 4'b0000, 32'h00000000, 1'b1);
        vecs[10] = mk(0, 4'hF, 32'h40302010, 4'hB, 4'b0100, 8'h30, 4'b0001, 32'h000000EF, 1'b1);
        vecs[11] = mk(0, 4'hF, 32'h40302010, 4'hB, 4'b1000, 8'h40, 4'b0010, 32'h0000DFEF, 1'b1);
        vecs[12] = mk(0, 4'hF, 32'h40302010, 4'hB, 4'b0001, 8'h10, 4'b0100, 32'h00CFDFEF, 1'b1);
        vecs[13] = mk(0, 4'hF, 32'h40302010, 4'hB, 4'b0010, 8'h20, 4'b1100, 32'hBFCFDFEF, 1'b1);
        vecs[14] = mk(0, 4'hF, 32'h40302010, 4'hB, 4'b1000, 8'h40, 4'b0101, 32'hBFCFDFEF, 1'b1);
        vecs[15] = mk(0, 4'hF, 32'h40302010, 4'hB, 4'b0001, 8'h10, 4'b0110, 32'hBFCFDFEF, 1'b1);
        vecs[16] = mk(0, 4'hF, 32'h40302010, 4'hB, 4'b0010, 8'h20, 4'b1100, 32'hBFCFDFEF, 1'b1);
        vecs[17] = mk(0, 4'hF, 32'h40302010, 4'hB, 4'b1000, 8'h40, 4'b0101, 32'hBFCFDFEF, 1'b1);

        drive(4'h0, 32'h0, 4'h0);
        do_reset();
        #1;
        check_outputs("idle", 4'h0, 8'h00, 4'h0, 32'h0, 1'b0);

        // Single request, response held for five cycles
        next_cycle(); drive(4'b0001, 32'h00000040, 4'h0); #1;
        check_outputs("single.grant", 4'b0001, 8'h40, 4'h0, 32'h0, 1'b0);
        next_cycle(); #1;
        check_outputs("single.flight", 4'h0, 8'h00, 4'h0, 32'h0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            next_cycle(); #1;
            check_outputs("single.hold", 4'h0, 8'h00, 4'b0001, 32'h000000BF, 1'b1);
        end
        next_cycle(); drive(4'b0001, 32'h00000040, 4'b0001); #1;
        check_outputs("single.pop", 4'h0, 8'h00, 4'b0001, 32'h000000BF, 1'b1);
        next_cycle(); #1;
        check_outputs("single.reissue", 4'b0001, 8'h40, 4'h0, 32'h000000BF, 1'b0);
        drive(4'h0, 32'h0, 4'h0);
        next_cycle(); #1;
        check_outputs("single.idle", 4'h0, 8'h00, 4'h0, 32'h000000BF, 1'b0);

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].rst_before) do_reset();
            next_cycle();
            drive(vecs[i].req_valid, vecs[i].req_data, vecs[i].rsp_ready);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_in,
                          vecs[i].exp_rv, vecs[i].exp_rd, vecs[i].exp_busy);
        end

        // Capture of slot 1 coincides with pop of slot 0
        do_reset();
        next_cycle(); drive(4'b0001, 32'h00000055, 4'h0); #1;
        check_outputs("sim.g0", 4'b0001, 8'h55, 4'h0, 32'h0, 1'b0);
        next_cycle(); drive(4'b0010, 32'h00000F00, 4'h0); #1;
        check_outputs("sim.g1", 4'b0010, 8'h0F, 4'h0, 32'h0, 1'b1);
        next_cycle(); drive(4'h0, 32'h0, 4'b0001); #1;
        check_outputs("sim.cap0", 4'h0, 8'h00, 4'b0001, 32'h000000AA, 1'b1);
        next_cycle(); drive(4'h0, 32'h0, 4'b0001); #1;
        check_outputs("sim.both", 4'h0, 8'h00, 4'b0010, 32'h0000F0AA, 1'b1);
        next_cycle(); drive(4'h0, 32'h0, 4'h0); #1;
        check_outputs("sim.wait", 4'h0, 8'h00, 4'b0010, 32'h0000F0AA, 1'b1);
        next_cycle(); drive(4'h0, 32'h0, 4'b0010); #1;
        check_outputs("sim.pop1", 4'h0, 8'h00, 4'b0010, 32'h0000F0AA, 1'b1);
        next_cycle(); drive(4'h0, 32'h0, 4'h0); #1;
        check_outputs("sim.drained", 4'h0, 8'h00, 4'h0, 32'h0000F0AA, 1'b0);

        // Reset the cycle after a grant: the late result must be dropped
        do_reset();
        next_cycle(); drive(4'b0100, 32'h00330000, 4'h0); #1;
        check_outputs("rmf.grant", 4'b0100, 8'h33, 4'h0, 32'h0, 1'b0);
        next_cycle(); rst_n = 1'b0; drive(4'h0, 32'h0, 4'h0); #1;
        check_outputs("rmf.flight", 4'h0, 8'h00, 4'h0, 32'h0, 1'b1);
        next_cycle(); rst_n = 1'b1; #1;
        check_outputs("rmf.after", 4'h0, 8'h00, 4'h0, 32'h0, 1'b0);
        next_cycle(); #1;
        check_outputs("rmf.quiet", 4'h0, 8'h00, 4'h0, 32'h0, 1'b0);
        next_cycle(); drive(4'hF, 32'h44332211, 4'h0); #1;
        check_outputs("rmf.ptr0", 4'b0001, 8'h11, 4'h0, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
